weight_bank_streamer: RTL and testbench

- Parametrised successor to the fixed per-layer weight constant blocks.
- Holds NUM_BANKS banks, each of NUM_WEIGHTS signed fixed-point weights plus one bias, in a runtime-writable register file.
- On request, streams one selected bank to a MAC datapath over a valid/ready handshake, in order w0..w(N-1), then bias.
- Sits between the host/config loader and the decoder/encoder neuron MAC units.

---
 rtl/figan_pkg.sv | 17 +
 rtl/weight_bank_regfile.sv | 49 ++++
 rtl/weight_bank_streamer.sv | 125 ++++++++++++
 tb/tb_weight_bank_streamer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/figan_pkg.sv
// Shared types and constants for the weight bank streaming path.
// Fixed-point format is Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS, signed.
package figan_pkg;

  localparam int FRAC_BITS      = 10;
  localparam int DATA_WIDTH_DEF = 16;

  typedef logic signed [DATA_WIDTH_DEF-1:0] word_t;

  typedef enum logic {IDLE, RUN} state_t;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_bank_regfile.sv
// Weight/bias storage: one write port, one registered read port addressed by (bank, idx).
// Read data updates only when rd_en is high; a same-address write in that cycle is forwarded.
module weight_bank_regfile #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_WEIGHTS = 16,
  parameter int NUM_BANKS   = 4,
  parameter int BW          = 2,
  parameter int IW          = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [BW-1:0]                wr_bank,
  input  logic [IW-1:0]                wr_addr,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  input  logic                         rd_en,
  input  logic [BW-1:0]                rd_bank,
  input  logic [IW-1:0]                rd_idx,
  output logic signed [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [NUM_BANKS][NUM_WEIGHTS+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int i = 0; i <= NUM_WEIGHTS; i++) begin
          mem[b][i] <= '0;
        end
      end
    end else if (wr_en) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
  end

  // Forwarding lets a stream started alongside a write to its own bank see the new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if (wr_en && wr_bank == rd_bank && wr_addr == rd_idx) begin
        rd_data <= wr_data;
      end else begin
        rd_data <= mem[rd_bank][rd_idx];
      end
    end
  end

endmodule

// File: rtl/weight_bank_streamer.sv
// Streams one bank (w0..wN-1, then bias) over valid/ready; first beat one cycle after start.
// Stalls hold data/idx/last stable; writes to the bank being streamed are rejected and flagged.
module weight_bank_streamer #(
  parameter int DATA_WIDTH  = figan_pkg::DATA_WIDTH_DEF,
  parameter int NUM_WEIGHTS = 16,
  parameter int NUM_BANKS   = 4,
  localparam int BW         = figan_pkg::clog2_min1(NUM_BANKS),
  localparam int IW         = $clog2(NUM_WEIGHTS + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [BW-1:0]                wr_bank,
  input  logic [IW-1:0]                wr_addr,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  output logic                         wr_err,
  input  logic                         err_clr,
  input  logic                         start,
  input  logic [BW-1:0]                rd_bank,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic [IW-1:0]                out_idx,
  output logic                         out_last
);

  import figan_pkg::*;

  localparam logic [IW-1:0] BIAS_IDX = IW'(NUM_WEIGHTS);

  state_t        state, state_nxt;
  logic [BW-1:0] cur_bank, bank_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic          rd_en;
  logic [BW-1:0] rd_sel_bank;
  logic [IW-1:0] rd_sel_idx;
  logic          start_err, wr_bad, wr_ok, xfer, at_bias;

  assign busy      = (state == RUN);
  assign out_valid = busy;
  assign at_bias   = (idx == BIAS_IDX);
  assign out_last  = busy && at_bias;
  assign out_idx   = idx;
  assign xfer      = out_valid && out_ready;

  assign wr_bad = wr_en && ((int'(wr_bank) >= NUM_BANKS) ||
                            (int'(wr_addr) > NUM_WEIGHTS) ||
                            (busy && wr_bank == cur_bank));
  assign wr_ok  = wr_en && !wr_bad;

  always_comb begin
    state_nxt   = state;
    bank_nxt    = cur_bank;
    idx_nxt     = idx;
    rd_en       = 1'b0;
    rd_sel_bank = cur_bank;
    rd_sel_idx  = idx;
    start_err   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (int'(rd_bank) < NUM_BANKS) begin
            state_nxt   = RUN;
            bank_nxt    = rd_bank;
            idx_nxt     = '0;
            rd_en       = 1'b1;
            rd_sel_bank = rd_bank;
            rd_sel_idx  = '0;
          end else begin
            start_err = 1'b1;
          end
        end
      end
      RUN: begin
        if (xfer) begin
          if (at_bias) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
          end else begin
            // Prefetch the next word so valid never drops mid-stream.
            idx_nxt    = idx + 1'b1;
            rd_en      = 1'b1;
            rd_sel_idx = idx + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cur_bank <= '0;
      idx      <= '0;
      wr_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cur_bank <= bank_nxt;
      idx      <= idx_nxt;
      wr_err   <= (wr_err && !err_clr) || wr_bad || start_err;
    end
  end

  weight_bank_regfile #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_WEIGHTS (NUM_WEIGHTS),
    .NUM_BANKS   (NUM_BANKS),
    .BW          (BW),
    .IW          (IW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_ok),
    .wr_bank (wr_bank),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_bank (rd_sel_bank),
    .rd_idx  (rd_sel_idx),
    .rd_data (out_data)
  );

endmodule

// File: tb/tb_weight_bank_streamer.sv
// Randomised bench for weight_bank_streamer against an array-based bank model.
// Three banks keep the 2-bit bank field able to encode an out-of-range bank.
module tb_weight_bank_streamer;

  localparam int NB = 3;
  localparam int NW = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               wr_en, err_clr, start, out_ready;
  logic [1:0]         wr_bank, rd_bank;
  logic [4:0]         wr_addr;
  logic signed [15:0] wr_data;
  logic               wr_err, busy, out_valid, out_last;
  logic signed [15:0] out_data;
  logic [4:0]         out_idx;

  weight_bank_streamer #(.DATA_WIDTH(16), .NUM_WEIGHTS(NW), .NUM_BANKS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_err(wr_err), .err_clr(err_clr), .start(start),
    .rd_bank(rd_bank), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] model [NB][NW+1];
  logic [15:0] q_d[$];
  int          q_i[$];
  bit          q_l[$];
  int          stall_viol, first_valid, busy_after, timed_out;

  logic [15:0] bank0_init [NW+1] = '{16'h0114, 16'h0108, 16'h00ee, 16'h00d5, 16'h00c2,
                                     16'h00b0, 16'h00a1, 16'h0093, 16'h0089, 16'h0080,
                                     16'hff79, 16'hfe73, 16'h0070, 16'h0108, 16'h010a,
                                     16'h0106, 16'h0001};

  task automatic model_write(input int b, input int a, input logic [15:0] d,
                             input bit streaming, input int sbank);
    if (b < NB && a <= NW && !(streaming && b == sbank)) model[b][a] = d;
  endtask

  task automatic model_clear();
    for (int b = 0; b < NB; b++)
      for (int i = 0; i <= NW; i++) model[b][i] = '0;
  endtask

  task automatic write_word(input int b, input int a, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_bank = b[1:0]; wr_addr = a[4:0]; wr_data = d;
    model_write(b, a, d, 1'b0, 0);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
  endtask

  // Runs one stream and records every accepted beat. wcyc = -1 writes in the start
  // cycle, >= 0 writes in that stream cycle, < -1 no write. scyc issues an extra start.
  task automatic stream(input int bank, input int mode, input int wcyc, input int wb,
                        input int wa, input logic [15:0] wd, input int scyc);
    logic [15:0] pd;
    logic [4:0]  pi;
    bit          pst, done;
    bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    q_d.delete(); q_i.delete(); q_l.delete();
    stall_viol = 0; timed_out = 0; done = 0; pst = 0; pd = '0; pi = '0;
    @(negedge clk);
    start = 1'b1; rd_bank = bank[1:0];
    if (wcyc == -1) begin
      wr_en = 1'b1; wr_bank = wb[1:0]; wr_addr = wa[4:0]; wr_data = wd;
      model_write(wb, wa, wd, 1'b0, 0);
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    first_valid = int'(out_valid);
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      wr_en = 1'b0; start = 1'b0;
      if (cyc == wcyc) begin
        wr_en = 1'b1; wr_bank = wb[1:0]; wr_addr = wa[4:0]; wr_data = wd;
        model_write(wb, wa, wd, 1'b1, bank);
      end
      if (cyc == scyc) begin start = 1'b1; rd_bank = 2'((bank + 1) % NB); end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[cyc % 4];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (pst && (out_data !== pd || out_idx !== pi)) stall_viol++;
      if (!out_valid) break;
      pst = !out_ready; pd = out_data; pi = out_idx;
      if (out_ready) begin
        q_d.push_back(out_data); q_i.push_back(int'(out_idx)); q_l.push_back(out_last);
        if (out_last) done = 1;
      end
      @(negedge clk);
    end
    wr_en = 1'b0; start = 1'b0;
    if (!done) timed_out = 1;
    busy_after = int'(busy);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vectors += 6;
    if (busy !== 1'b0)      begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out_valid); end
    if (out_last !== 1'b0)  begin miscompares++; $display("FAIL reset_last got %b want 0", out_last); end
    if (wr_err !== 1'b0)    begin miscompares++; $display("FAIL reset_err got %b want 0", wr_err); end
    if (out_data !== 16'h0) begin miscompares++; $display("FAIL reset_data got %h want 0000", out_data); end
    if (out_idx !== 5'd0)   begin miscompares++; $display("FAIL reset_idx got %0d want 0", out_idx); end
    model_clear();
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_full_stream();
    for (int i = 0; i <= NW; i++) write_word(0, i, bank0_init[i]);
    stream(0, 0, -2, 0, 0, 16'h0, -1);
    vectors += 4;
    if (first_valid !== 1) begin miscompares++; $display("FAIL full_latency got valid=%0d want 1", first_valid); end
    if (q_d.size() != 17)  begin miscompares++; $display("FAIL full_count got %0d want 17", q_d.size()); end
    if (busy_after !== 0)  begin miscompares++; $display("FAIL full_busy_after got %0d want 0", busy_after); end
    if (q_d.size() > 16 && q_d[16] !== 16'h0001) begin
      miscompares++; $display("FAIL full_bias got %h want 0001", q_d[16]);
    end
    for (int k = 0; k < q_d.size() && k < 17; k++) begin
      vectors++;
      if (q_d[k] !== model[0][k] || q_i[k] != k || q_l[k] != (k == 16)) begin
        miscompares++;
        $display("FAIL full_beat%0d got d=%h i=%0d l=%0b want d=%h i=%0d l=%0b",
                 k, q_d[k], q_i[k], q_l[k], model[0][k], k, k == 16);
      end
    end
  endtask

  task automatic test_stall();
    stream(0, 1, -2, 0, 0, 16'h0, -1);
    vectors += 3;
    if (q_d.size() != 17)  begin miscompares++; $display("FAIL stall_count got %0d want 17", q_d.size()); end
    if (stall_viol != 0)   begin miscompares++; $display("FAIL stall_hold got %0d changes want 0", stall_viol); end
    if (busy_after !== 0)  begin miscompares++; $display("FAIL stall_busy_after got %0d want 0", busy_after); end
    for (int k = 0; k < q_d.size() && k < 17; k++) begin
      vectors++;
      if (q_d[k] !== model[0][k] || q_i[k] != k || q_l[k] != (k == 16)) begin
        miscompares++;
        $display("FAIL stall_beat%0d got d=%h i=%0d want d=%h i=%0d", k, q_d[k], q_i[k], model[0][k], k);
      end
    end
  endtask

  task automatic test_write_during_stream();
    for (int b = 1; b < NB; b++)
      for (int i = 0; i <= NW; i++) write_word(b, i, 16'($urandom));
    stream(0, 0, 2, 0, 3, 16'h7fff, -1);
    vectors++;
    if (wr_err !== 1'b1) begin miscompares++; $display("FAIL busy_write_err got %b want 1", wr_err); end
    pulse_clr();
    stream(0, 2, 2, 1, 3, 16'h8000, -1);
    vectors++;
    if (wr_err !== 1'b0) begin miscompares++; $display("FAIL other_write_err got %b want 0", wr_err); end
    for (int b = 0; b < 2; b++) begin
      stream(b, 2, -2, 0, 0, 16'h0, -1);
      vectors++;
      if (q_d.size() != 17) begin miscompares++; $display("FAIL wds_count b%0d got %0d want 17", b, q_d.size()); end
      for (int k = 0; k < q_d.size() && k < 17; k++) begin
        vectors++;
        if (q_d[k] !== model[b][k] || q_i[k] != k) begin
          miscompares++;
          $display("FAIL wds_beat b%0d k%0d got d=%h i=%0d want d=%h", b, k, q_d[k], q_i[k], model[b][k]);
        end
      end
    end
    vectors += 2;
    if (q_d.size() > 3 && q_d[3] !== 16'h8000) begin miscompares++; $display("FAIL bank1_idx3 got %h want 8000", q_d[3]); end
    if (model[0][3] !== bank0_init[3]) begin miscompares++; $display("FAIL bank0_model got %h want %h", model[0][3], bank0_init[3]); end
  endtask

  task automatic test_bad_writes();
    write_word(0, 17, 16'h1234);
    vectors++;
    if (wr_err !== 1'b1) begin miscompares++; $display("FAIL addr17_err got %b want 1", wr_err); end
    pulse_clr();
    vectors++;
    if (wr_err !== 1'b0) begin miscompares++; $display("FAIL err_clr got %b want 0", wr_err); end
    write_word(3, 2, 16'h5555);
    vectors++;
    if (wr_err !== 1'b1) begin miscompares++; $display("FAIL bank_oor_err got %b want 1", wr_err); end
    @(negedge clk); err_clr = 1'b1; wr_en = 1'b1; wr_bank = 2'd0; wr_addr = 5'd20; wr_data = 16'h3333;
    @(negedge clk); err_clr = 1'b0; wr_en = 1'b0;
    vectors++;
    if (wr_err !== 1'b1) begin miscompares++; $display("FAIL clr_vs_err got %b want 1", wr_err); end
    pulse_clr();
    write_word(2, 16, 16'hbeef);
    vectors++;
    if (wr_err !== 1'b0) begin miscompares++; $display("FAIL bias_write_err got %b want 0", wr_err); end
    @(negedge clk); start = 1'b1; rd_bank = 2'd3;
    @(negedge clk); start = 1'b0;
    vectors += 2;
    if (wr_err !== 1'b1) begin miscompares++; $display("FAIL start_oor_err got %b want 1", wr_err); end
    if (busy !== 1'b0)   begin miscompares++; $display("FAIL start_oor_busy got %b want 0", busy); end
    pulse_clr();
    for (int b = 0; b < NB; b += 2) begin
      stream(b, 2, -2, 0, 0, 16'h0, -1);
      for (int k = 0; k < q_d.size() && k < 17; k++) begin
        vectors++;
        if (q_d[k] !== model[b][k]) begin
          miscompares++; $display("FAIL bad_wr_store b%0d k%0d got %h want %h", b, k, q_d[k], model[b][k]);
        end
      end
    end
  endtask

  task automatic test_start_busy();
    stream(0, 0, -2, 0, 0, 16'h0, 3);
    vectors += 2;
    if (q_d.size() != 17 || q_d[16] !== model[0][16]) begin
      miscompares++; $display("FAIL busy_start_count got %0d want 17", q_d.size());
    end
    if (wr_err !== 1'b0) begin miscompares++; $display("FAIL busy_start_err got %b want 0", wr_err); end
    for (int k = 0; k < q_d.size() && k < 17; k++) begin
      vectors++;
      if (q_d[k] !== model[0][k]) begin miscompares++; $display("FAIL busy_start_beat%0d got %h want %h", k, q_d[k], model[0][k]); end
    end
    stream(0, 0, -2, 0, 0, 16'h0, 16);
    @(negedge clk);
    vectors += 2;
    if (busy_after !== 0) begin miscompares++; $display("FAIL last_start_busy got %0d want 0", busy_after); end
    if (busy !== 1'b0)    begin miscompares++; $display("FAIL last_start_busy2 got %b want 0", busy); end
    stream(2, 1, -1, 2, 0, 16'h0200, -1);
    vectors += 2;
    if (q_d.size() < 1 || q_d[0] !== 16'h0200) begin
      miscompares++; $display("FAIL same_cycle_write got %h want 0200", (q_d.size() > 0) ? q_d[0] : 16'hxxxx);
    end
    if (q_d.size() != 17) begin miscompares++; $display("FAIL same_cycle_count got %0d want 17", q_d.size()); end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 8; it++) begin
      int b;
      b = $urandom_range(0, NB - 1);
      stream(b, 2, $urandom_range(0, 10), $urandom_range(0, NB - 1), $urandom_range(0, NW),
             16'($urandom), -1);
      vectors += 2;
      if (q_d.size() != 17) begin miscompares++; $display("FAIL b2b%0d_count got %0d want 17", it, q_d.size()); end
      if (stall_viol != 0)  begin miscompares++; $display("FAIL b2b%0d_hold got %0d want 0", it, stall_viol); end
      for (int k = 0; k < q_d.size() && k < 17; k++) begin
        vectors++;
        if (q_d[k] !== model[b][k] || q_i[k] != k || q_l[k] != (k == 16)) begin
          miscompares++;
          $display("FAIL b2b%0d_beat%0d got d=%h i=%0d want d=%h i=%0d", it, k, q_d[k], q_i[k], model[b][k], k);
        end
      end
      pulse_clr();
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk); start = 1'b1; rd_bank = 2'd0; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 40 && out_idx !== 5'd5; c++) @(negedge clk);
    vectors++;
    if (out_idx !== 5'd5 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL mid_reach got idx=%0d want 5", out_idx);
    end
    rst_n = 1'b0;
    #1;
    vectors += 5;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_valid got %b want 0", out_valid); end
    if (busy !== 1'b0)      begin miscompares++; $display("FAIL arst_busy got %b want 0", busy); end
    if (out_data !== 16'h0) begin miscompares++; $display("FAIL arst_data got %h want 0000", out_data); end
    if (out_idx !== 5'd0)   begin miscompares++; $display("FAIL arst_idx got %0d want 0", out_idx); end
    if (out_last !== 1'b0)  begin miscompares++; $display("FAIL arst_last got %b want 0", out_last); end
    model_clear();
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    for (int b = 0; b < NB; b++) begin
      stream(b, 0, -2, 0, 0, 16'h0, -1);
      vectors++;
      if (q_d.size() != 17) begin miscompares++; $display("FAIL post_rst b%0d count got %0d want 17", b, q_d.size()); end
      for (int k = 0; k < q_d.size() && k < 17; k++) begin
        vectors++;
        if (q_d[k] !== model[b][k]) begin miscompares++; $display("FAIL post_rst b%0d k%0d got %h want %h", b, k, q_d[k], model[b][k]); end
      end
    end
  endtask

  initial begin
    wr_en = 1'b0; err_clr = 1'b0; start = 1'b0; out_ready = 1'b0;
    wr_bank = '0; rd_bank = '0; wr_addr = '0; wr_data = '0;
    test_reset();
    test_full_stream();
    test_stall();
    test_write_during_stream();
    test_bad_writes();
    test_start_busy();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
